llnn_axi_engine: RTL and testbench

- Parametrised AXI-Lite front end for a LUT inference network of any width and pipeline depth.
- The network itself is external: driven through `net_i`, returned on `net_o`.
- Adds behaviour the fixed-size controller lacks: START/BUSY/DONE handshake, registered launch of inputs, NET_LATENCY-aware capture of results, interrupt, soft reset.
- Sits between the PS AXI-Lite master and a combinational or pipelined `top` network instance.

---
 rtl/llnn_axi_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_llnn_axi_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/llnn_axi_engine.sv
`default_nettype none
// ============================================================================
// Module   : llnn_axi_engine
// Purpose  : AXI-Lite front end for an external LUT inference network.
//            Provides INPUT word registers, a START/BUSY/DONE handshake,
//            a registered launch vector (net_i), NET_LATENCY-aware capture
//            of net_o, a level interrupt and a soft reset.
// Options  : define LLNN_PERF_CNT_EN to add the CYCLES (0x00C) and
//            RUNS (0x010) counters; when undefined both addresses read 0.
// Revision : 1.0 - initial release
// ============================================================================
module llnn_axi_engine #(
   parameter int NET_INPUTS  = 400,
   parameter int NET_OUTPUTS = 4,
   parameter int NET_LATENCY = 0,
   parameter int ADDR_W      = 14
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ADDR_W-1:0]      S_AXI_AWADDR,
   input  logic                   S_AXI_AWVALID,
   output logic                   S_AXI_AWREADY,
   input  logic [31:0]            S_AXI_WDATA,
   input  logic [3:0]             S_AXI_WSTRB,
   input  logic                   S_AXI_WVALID,
   output logic                   S_AXI_WREADY,
   output logic [1:0]             S_AXI_BRESP,
   output logic                   S_AXI_BVALID,
   input  logic                   S_AXI_BREADY,
   input  logic [ADDR_W-1:0]      S_AXI_ARADDR,
   input  logic                   S_AXI_ARVALID,
   output logic                   S_AXI_ARREADY,
   output logic [31:0]            S_AXI_RDATA,
   output logic [1:0]             S_AXI_RRESP,
   output logic                   S_AXI_RVALID,
   input  logic                   S_AXI_RREADY,
   output logic [NET_INPUTS-1:0]  net_i,
   input  logic [NET_OUTPUTS-1:0] net_o,
   output logic                   irq
);
   localparam int IW = (NET_INPUTS + 31) / 32;
   localparam int CW = (NET_LATENCY > 0) ? $clog2(NET_LATENCY + 1) : 1;
   localparam int WW = ADDR_W - 2;
   localparam logic [WW-1:0] W_CTRL   = WW'(0);
   localparam logic [WW-1:0] W_STATUS = WW'(1);
   localparam logic [WW-1:0] W_RESULT = WW'(2);
`ifdef LLNN_PERF_CNT_EN
   localparam logic [WW-1:0] W_CYCLES = WW'(3);
   localparam logic [WW-1:0] W_RUNS   = WW'(4);
`endif

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;
   state_t state, state_nxt;

   logic              wr_hs, rd_hs;
   logic [WW-1:0]     aw_word, ar_word;
   logic [IW-1:0]     in_wr_hit, in_rd_hit;
   logic [31:0]       in_regs [IW];
   logic [31:0]       in_rd_or [IW+1];
   logic [NET_INPUTS-1:0] in_flat;
   logic [31:0]       byte_mask;
   logic              in_wr_err, ctrl_wr, status_wr;
   logic              start_wr, srst, launch, capture, done_clr;
   logic              busy, done, irq_en;
   logic [CW-1:0]     cnt;
   logic [31:0]       result, rd_mux;
   logic              unused_addr_bits;

   // Writes take address and data in the same beat; one outstanding response
   assign wr_hs         = S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID;
   assign S_AXI_AWREADY = wr_hs;
   assign S_AXI_WREADY  = wr_hs;
   assign rd_hs         = S_AXI_ARVALID & ~S_AXI_RVALID;
   assign S_AXI_ARREADY = rd_hs;
   assign S_AXI_RRESP   = 2'b00;

   assign aw_word   = S_AXI_AWADDR[ADDR_W-1:2];
   assign ar_word   = S_AXI_ARADDR[ADDR_W-1:2];
   assign byte_mask = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}},
                       {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
   assign unused_addr_bits = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign in_rd_or[0] = 32'd0;

   generate
      for (genvar k = 0; k < IW; k++) begin : g_in_word
         // Only bits below NET_INPUTS exist; the rest of the last word stays 0
         localparam logic [31:0] KEEP = ((k + 1) * 32 <= NET_INPUTS) ? 32'hFFFF_FFFF
                                        : ((32'd1 << (NET_INPUTS - k * 32)) - 32'd1);
         assign in_wr_hit[k]  = (aw_word == WW'(64 + k));
         assign in_rd_hit[k]  = (ar_word == WW'(64 + k));
         assign in_rd_or[k+1] = in_rd_or[k] | (in_rd_hit[k] ? in_regs[k] : 32'd0);
         // Byte-strobed INPUT word update, frozen while an inference runs
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               in_regs[k] <= 32'd0;
            else if (wr_hs && in_wr_hit[k] && !busy)
               in_regs[k] <= (in_regs[k] & ~(byte_mask & KEEP)) |
                             (S_AXI_WDATA & byte_mask & KEEP);
         end
      end
      for (genvar i = 0; i < NET_INPUTS; i++) begin : g_flat
         assign in_flat[i] = in_regs[i / 32][i % 32];
      end
   endgenerate

   assign in_wr_err = wr_hs & (|in_wr_hit) & busy;
   assign ctrl_wr   = wr_hs & (aw_word == W_CTRL) & S_AXI_WSTRB[0];
   assign status_wr = wr_hs & (aw_word == W_STATUS) & S_AXI_WSTRB[0];
   assign srst      = ctrl_wr & S_AXI_WDATA[1];
   assign start_wr  = ctrl_wr & S_AXI_WDATA[0];
   // Soft reset beats a START carried in the same write
   assign launch    = start_wr & ~srst & (state == IDLE);
   assign done_clr  = status_wr & S_AXI_WDATA[1];
   assign capture   = (state == RUN) & (cnt == '0) & ~srst;
   assign busy      = (state == RUN);
   assign irq       = done & irq_en;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next state: launch on START, return once the countdown expires
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (launch) state_nxt = RUN;
         RUN:     if (cnt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (srst) state_nxt = IDLE;
   end

   // Launch vector, latency countdown, result capture and DONE/IRQ_EN flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         net_i  <= '0;
         cnt    <= '0;
         done   <= 1'b0;
         result <= 32'd0;
         irq_en <= 1'b0;
      end else begin
         if (ctrl_wr) irq_en <= S_AXI_WDATA[2];
         if (launch)  net_i  <= in_flat;
         if (srst) begin
            cnt    <= '0;
            done   <= 1'b0;
            result <= 32'd0;
         end else if (launch) begin
            cnt  <= CW'(NET_LATENCY);
            done <= 1'b0;
         end else if (capture) begin
            result <= 32'(net_o);
            done   <= 1'b1;
         end else begin
            if (busy)     cnt  <= cnt - CW'(1);
            if (done_clr) done <= 1'b0;
         end
      end
   end

`ifdef LLNN_PERF_CNT_EN
   logic [31:0] cycles, runs;

   // RUN-cycle count of the latest inference and wrapping completed-run tally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycles <= 32'd0;
         runs   <= 32'd0;
      end else if (srst) begin
         cycles <= 32'd0;
         runs   <= 32'd0;
      end else begin
         if (launch)    cycles <= 32'd0;
         else if (busy) cycles <= cycles + 32'd1;
         if (capture)   runs   <= runs + 32'd1;
      end
   end
`endif

   // Read data selection; unmapped addresses fall through to 0
   always_comb begin
      rd_mux = in_rd_or[IW];
      case (ar_word)
         W_CTRL:   rd_mux = {29'd0, irq_en, 2'b00};
         W_STATUS: rd_mux = {30'd0, done, busy};
         W_RESULT: rd_mux = result;
`ifdef LLNN_PERF_CNT_EN
         W_CYCLES: rd_mux = cycles;
         W_RUNS:   rd_mux = runs;
`endif
         default:  ;
      endcase
   end

   // Write response channel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP  <= 2'b00;
      end else if (wr_hs) begin
         S_AXI_BVALID <= 1'b1;
         S_AXI_BRESP  <= in_wr_err ? 2'b10 : 2'b00;
      end else if (S_AXI_BREADY) begin
         S_AXI_BVALID <= 1'b0;
      end
   end

   // Read response channel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA  <= 32'd0;
      end else if (rd_hs) begin
         S_AXI_RVALID <= 1'b1;
         S_AXI_RDATA  <= rd_mux;
      end else if (S_AXI_RREADY) begin
         S_AXI_RVALID <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_llnn_axi_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_llnn_axi_engine
// Purpose  : Directed self-checking bench for llnn_axi_engine with
//            NET_INPUTS=400, NET_OUTPUTS=4, NET_LATENCY=3 and an external
//            3-stage network model net_o = ~net_i[3:0].
// Revision : 1.0 - initial release
// ============================================================================
module tb_llnn_axi_engine;
   localparam int NI = 400;
   localparam int NO = 4;
   localparam int NL = 3;
   localparam int AW = 14;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] awaddr = '0;
   logic          awvalid = 1'b0;
   logic          awready;
   logic [31:0]   wdata = '0;
   logic [3:0]    wstrb = '0;
   logic          wvalid = 1'b0;
   logic          wready;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready = 1'b1;
   logic [AW-1:0] araddr = '0;
   logic          arvalid = 1'b0;
   logic          arready;
   logic [31:0]   rdata;
   logic [1:0]    rresp;
   logic          rvalid;
   logic          rready = 1'b1;
   logic [NI-1:0] net_i;
   logic [NO-1:0] net_o;
   logic          irq;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   llnn_axi_engine #(
      .NET_INPUTS(NI), .NET_OUTPUTS(NO), .NET_LATENCY(NL), .ADDR_W(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .net_i(net_i), .net_o(net_o), .irq(irq)
   );

   // External network: three register stages of ~net_i[3:0]
   logic [3:0] p1 = 4'd0, p2 = 4'd0, p3 = 4'd0;
   always_ff @(posedge clk) begin
      p1 <= ~net_i[3:0];
      p2 <= p1;
      p3 <= p2;
   end
   assign net_o = p3;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
      end
   endtask

   // Handshake at the posedge ending cycle T; returns at the negedge of T+1
   task automatic axi_wr(input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [1:0] resp);
      int n;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      #1;
      n = 0;
      while (!(awready && wready) && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk("wr_ready", 32'(awready & wready), 32'd1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      n = 0;
      while (!bvalid && n < 20) begin
         @(negedge clk); n++;
      end
      chk("bvalid", 32'(bvalid), 32'd1);
      resp = bresp;
   endtask

   task automatic axi_rd(input logic [AW-1:0] a, output logic [31:0] d,
                         output logic [1:0] resp);
      int n;
      @(negedge clk);
      araddr = a; arvalid = 1'b1;
      #1;
      n = 0;
      while (!arready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk("ar_ready", 32'(arready), 32'd1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      n = 0;
      while (!rvalid && n < 20) begin
         @(negedge clk); n++;
      end
      chk("rvalid", 32'(rvalid), 32'd1);
      d = rdata;
      resp = rresp;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  r;
      logic [31:0] d;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_irq",     32'(irq), 32'd0);
      chk("rst_net_lo",  net_i[31:0], 32'd0);
      chk("rst_net_hi",  32'(net_i[399:384]), 32'd0);
      chk("rst_bvalid",  32'(bvalid), 32'd0);
      chk("rst_rvalid",  32'(rvalid), 32'd0);
      chk("rst_awready", 32'(awready), 32'd0);
      rst_n = 1'b1;
      axi_rd(14'h004, d, r); chk("rst_status", d, 32'd0);
      axi_rd(14'h008, d, r); chk("rst_result", d, 32'd0);

      // INPUT registers, last-word truncation and byte strobes
      axi_wr(14'h100, 32'hA5A5_A5A5, 4'hF, r); chk("in0_bresp", 32'(r), 32'd0);
      axi_wr(14'h130, 32'hFFFF_FFFF, 4'hF, r);
      axi_rd(14'h100, d, r); chk("in0_rd", d, 32'hA5A5_A5A5);
      axi_rd(14'h130, d, r); chk("in12_rd", d, 32'h0000_FFFF);
      chk("net_hi_prestart", 32'(net_i[399:384]), 32'd0);
      axi_wr(14'h104, 32'h1122_3344, 4'hF, r);
      axi_wr(14'h104, 32'hAABB_CCDD, 4'h5, r);
      axi_rd(14'h104, d, r); chk("in1_strb", d, 32'h11BB_33DD);

      // Unmapped accesses
      axi_wr(14'h050, 32'hFFFF_FFFF, 4'hF, r); chk("unmap_bresp", 32'(r), 32'd0);
      axi_rd(14'h200, d, r); chk("unmap_rd", d, 32'd0); chk("unmap_rresp", 32'(r), 32'd0);
      axi_rd(14'h00C, d, r); chk("cycles_idle", d, 32'd0);

      // IRQ_EN
      axi_wr(14'h000, 32'h4, 4'hF, r);
      axi_rd(14'h000, d, r); chk("ctrl_irqen", d, 32'h4);

      // Run 1: INPUT[0]=5 -> RESULT=~5=0xA, capture at end of T+4
      axi_wr(14'h100, 32'h5, 4'hF, r);
      axi_wr(14'h000, 32'h5, 4'hF, r);            // START at T, now T+1
      chk("net_hi_launch", 32'(net_i[399:384]), 32'h0000_FFFF);
      chk("net_lo_launch", net_i[31:0], 32'h5);
      chk("irq_t1", 32'(irq), 32'd0);
      @(negedge clk);                             // T+2
      axi_rd(14'h004, d, r);                      // handshake T+3
      chk("status_t3", d, 32'h1);                 // now T+4
      chk("irq_t4", 32'(irq), 32'd0);
      @(negedge clk);                             // T+5
      chk("irq_t5", 32'(irq), 32'd1);
      axi_rd(14'h004, d, r); chk("status_done", d, 32'h2);
      axi_rd(14'h008, d, r); chk("result_a", d, 32'hA);
      axi_rd(14'h000, d, r); chk("ctrl_start_rd0", d, 32'h4);

      // DONE write-1-to-clear drops irq
      axi_wr(14'h004, 32'h2, 4'hF, r);
      chk("irq_cleared", 32'(irq), 32'd0);
      axi_rd(14'h004, d, r); chk("status_cleared", d, 32'd0);

      // Run 2: INPUT write while BUSY, second START on the capture cycle
      axi_wr(14'h108, 32'h1234_5678, 4'hF, r);
      axi_wr(14'h000, 32'h5, 4'hF, r);            // START at T
      axi_wr(14'h108, 32'hDEAD_BEEF, 4'hF, r);    // handshake T+2
      chk("busy_bresp", 32'(r), 32'd2);
      axi_wr(14'h000, 32'h5, 4'hF, r);            // handshake T+4
      chk("start_busy_bresp", 32'(r), 32'd0);
      axi_rd(14'h004, d, r); chk("run2_done", d, 32'h2);
      axi_rd(14'h108, d, r); chk("in2_kept", d, 32'h1234_5678);
      axi_wr(14'h004, 32'h2, 4'hF, r);
      repeat (10) @(negedge clk);
      axi_rd(14'h004, d, r); chk("single_done", d, 32'd0);

      // Run 3: full run, then performance counters
      axi_wr(14'h000, 32'h5, 4'hF, r);
      repeat (6) @(negedge clk);
      chk("irq_run3", 32'(irq), 32'd1);
`ifdef LLNN_PERF_CNT_EN
      axi_rd(14'h00C, d, r); chk("cycles_run3", d, 32'd4);
      axi_rd(14'h010, d, r); chk("runs_run3", d, 32'd3);
`else
      axi_rd(14'h00C, d, r); chk("cycles_off", d, 32'd0);
      axi_rd(14'h010, d, r); chk("runs_off", d, 32'd0);
`endif

      // Run 4: START clears DONE, then SOFT_RST mid-run
      axi_wr(14'h000, 32'h5, 4'hF, r);            // START at T, DONE was 1
      chk("start_clears_done", 32'(irq), 32'd0);
      axi_wr(14'h000, 32'h6, 4'hF, r);            // SOFT_RST at T+2
      axi_rd(14'h004, d, r); chk("srst_status", d, 32'd0);
      repeat (10) @(negedge clk);
      axi_rd(14'h004, d, r); chk("srst_no_done", d, 32'd0);
      axi_rd(14'h008, d, r); chk("srst_result", d, 32'd0);
      axi_rd(14'h000, d, r); chk("srst_irqen_kept", d, 32'h4);
      axi_rd(14'h100, d, r); chk("srst_in0_kept", d, 32'h5);
      chk("srst_net_kept", 32'(net_i[399:384]), 32'h0000_FFFF);
`ifdef LLNN_PERF_CNT_EN
      axi_rd(14'h00C, d, r); chk("srst_cycles", d, 32'd0);
      axi_rd(14'h010, d, r); chk("srst_runs", d, 32'd0);
`endif

      // SOFT_RST together with START: no launch
      axi_wr(14'h000, 32'h7, 4'hF, r);
      axi_rd(14'h004, d, r); chk("srst_start_nolaunch", d, 32'd0);

      // Run 5: full run after soft reset
      axi_wr(14'h000, 32'h5, 4'hF, r);
      repeat (6) @(negedge clk);
      axi_rd(14'h008, d, r); chk("result_run5", d, 32'hA);
`ifdef LLNN_PERF_CNT_EN
      axi_rd(14'h00C, d, r); chk("cycles_run5", d, 32'd4);
      axi_rd(14'h010, d, r); chk("runs_run5", d, 32'd1);
`endif

      // Asynchronous reset mid-run
      axi_wr(14'h000, 32'h5, 4'hF, r);            // now T+1
      rst_n = 1'b0;
      @(negedge clk);
      chk("arst_net", 32'(net_i[399:384]), 32'd0);
      chk("arst_irq", 32'(irq), 32'd0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      axi_rd(14'h004, d, r); chk("arst_status", d, 32'd0);
      axi_rd(14'h008, d, r); chk("arst_result", d, 32'd0);
      axi_rd(14'h100, d, r); chk("arst_in0", d, 32'd0);
      axi_rd(14'h000, d, r); chk("arst_ctrl", d, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
